// File: rtl/bypass_pkg.sv
// Shared types and helpers for the operand bypass network.
// Widths here are the defaults the top module is built around.
package bypass_pkg;

    localparam int PKG_XLEN  = 32;
    localparam int PKG_NREGS = 32;

    // Register index width; a single register still needs one bit.
    function automatic int rw_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int PKG_RW = rw_of(PKG_NREGS);

    typedef logic [PKG_RW-1:0] reg_idx_t;

    typedef struct packed {
        logic                valid;
        reg_idx_t            rd;
        logic [PKG_XLEN-1:0] data;
        logic                is_load;
    } wb_bus_t;

endpackage

// File: rtl/bypass_scoreboard_if.sv
// Writeback, execute-operand and hazard signals of the bypass network.
// master drives writebacks and operands; slave returns forwarding.
interface bypass_scoreboard_if #(
    parameter int NUM_WB    = 3,
    parameter int NUM_LANES = 4,
    parameter int XLEN      = 32,
    parameter int RW        = 5
);
    logic [NUM_WB-1:0]                    wb_valid;
    logic [NUM_WB-1:0][RW-1:0]            wb_rd;
    logic [NUM_WB-1:0][XLEN-1:0]          wb_data;
    logic [NUM_WB-1:0]                    wb_is_load;
    logic [NUM_LANES-1:0]                 ex_valid;
    logic [2*NUM_LANES-1:0][RW-1:0]       ex_rs;
    logic                                 ld_issue_valid;
    logic [RW-1:0]                        ld_issue_rd;
    logic                                 flush;
    logic [2*NUM_LANES-1:0]               fwd_en;
    logic [2*NUM_LANES-1:0][XLEN-1:0]     fwd_data;
    logic                                 stall;
    logic [15:0]                          stall_cnt;

    modport master (
        output wb_valid, wb_rd, wb_data, wb_is_load,
        output ex_valid, ex_rs, ld_issue_valid, ld_issue_rd, flush,
        input  fwd_en, fwd_data, stall, stall_cnt
    );

    modport slave (
        input  wb_valid, wb_rd, wb_data, wb_is_load,
        input  ex_valid, ex_rs, ld_issue_valid, ld_issue_rd, flush,
        output fwd_en, fwd_data, stall, stall_cnt
    );

endinterface

// File: rtl/bypass_select.sv
// Priority selector for one source operand slot.
// Candidate 0 has the highest priority; register 0 never matches.
module bypass_select #(
    parameter int NUM_CAND = 6,
    parameter int XLEN     = 32,
    parameter int RW       = 5
) (
    input  logic [NUM_CAND-1:0]           cand_valid,
    input  logic [NUM_CAND-1:0][RW-1:0]   cand_rd,
    input  logic [NUM_CAND-1:0][XLEN-1:0] cand_data,
    input  logic [RW-1:0]                 rs,
    output logic                          hit,
    output logic [XLEN-1:0]               data
);

    // Scan from lowest priority upward so the lowest index is last to win.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int i = NUM_CAND - 1; i >= 0; i--) begin
            if (cand_valid[i] && (cand_rd[i] == rs) && (rs != '0)) begin
                hit  = 1'b1;
                data = cand_data[i];
            end
        end
    end

endmodule

// File: rtl/bypass_scoreboard.sv
// Result forwarding from writeback ports and a WB+1 stage to all
// execute operands, plus a load scoreboard raising load-use stalls.
module bypass_scoreboard
    import bypass_pkg::*;
#(
    parameter int NUM_WB           = 3,
    parameter int NUM_LANES        = 4,
    parameter int XLEN             = PKG_XLEN,
    parameter int NREGS            = PKG_NREGS,
    parameter bit RF_WRITE_THROUGH = 1'b0
) (
    input logic          clk,
    input logic          rst,
    bypass_scoreboard_if.slave bus
);

    localparam int RW = rw_of(NREGS);
    localparam int NS = 2 * NUM_LANES;
    localparam int NC = 2 * NUM_WB;

    wb_bus_t                     wb_cur [NUM_WB];
    logic [NUM_WB-1:0]           wb1_valid;
    logic [NUM_WB-1:0][RW-1:0]   wb1_rd;
    logic [NUM_WB-1:0][XLEN-1:0] wb1_data;

    logic [NC-1:0]               c_valid;
    logic [NC-1:0][RW-1:0]       c_rd;
    logic [NC-1:0][XLEN-1:0]     c_data;

    logic [NS-1:0]               fwd_en_w;
    logic [NS-1:0][XLEN-1:0]     fwd_data_w;

    logic [NREGS-1:0]            busy_q;
    logic [NREGS-1:0]            busy_d;
    logic [NS-1:0]               ret_hit;
    logic                        stall_w;
    logic [15:0]                 cnt_q;

    // Bundle each writeback port for the scoreboard and selectors.
    always_comb begin
        for (int p = 0; p < NUM_WB; p++) begin
            wb_cur[p].valid   = bus.wb_valid[p];
            wb_cur[p].rd      = bus.wb_rd[p];
            wb_cur[p].data    = bus.wb_data[p];
            wb_cur[p].is_load = bus.wb_is_load[p];
        end
    end

    generate
        if (RF_WRITE_THROUGH) begin : g_wt
            assign wb1_valid = '0;
            assign wb1_rd    = '0;
            assign wb1_data  = '0;
        end else begin : g_wb1
            // WB+1 stage: last cycle's writes, dropped on flush or reset.
            always_ff @(posedge clk) begin
                for (int p = 0; p < NUM_WB; p++) begin
                    wb1_valid[p] <= wb_cur[p].valid & ~bus.flush & ~rst;
                    wb1_rd[p]    <= wb_cur[p].rd;
                    wb1_data[p]  <= wb_cur[p].data;
                end
            end
        end
    endgenerate

    // Current ports rank above WB+1 since they carry newer values.
    always_comb begin
        for (int p = 0; p < NUM_WB; p++) begin
            c_valid[p]          = wb_cur[p].valid;
            c_rd[p]             = wb_cur[p].rd;
            c_data[p]           = wb_cur[p].data;
            c_valid[NUM_WB + p] = wb1_valid[p];
            c_rd[NUM_WB + p]    = wb1_rd[p];
            c_data[NUM_WB + p]  = wb1_data[p];
        end
    end

    generate
        for (genvar s = 0; s < NS; s++) begin : g_slot
            bypass_select #(
                .NUM_CAND (NC),
                .XLEN     (XLEN),
                .RW       (RW)
            ) u_sel (
                .cand_valid (c_valid),
                .cand_rd    (c_rd),
                .cand_data  (c_data),
                .rs         (bus.ex_rs[s]),
                .hit        (fwd_en_w[s]),
                .data       (fwd_data_w[s])
            );
        end
    endgenerate

    assign bus.fwd_en   = fwd_en_w;
    assign bus.fwd_data = fwd_data_w;

    // Load-use hazard unless the load result arrives this very cycle.
    always_comb begin
        stall_w = 1'b0;
        for (int s = 0; s < NS; s++) begin
            ret_hit[s] = 1'b0;
            for (int p = 0; p < NUM_WB; p++) begin
                if (wb_cur[p].valid && wb_cur[p].is_load &&
                    (wb_cur[p].rd == bus.ex_rs[s]))
                    ret_hit[s] = 1'b1;
            end
            if (bus.ex_valid[s/2] && (bus.ex_rs[s] != '0) &&
                busy_q[bus.ex_rs[s]] && !ret_hit[s])
                stall_w = 1'b1;
        end
    end

    assign bus.stall = stall_w;

    // Next busy vector: returns clear, a younger issue sets, flush wins.
    always_comb begin
        busy_d = busy_q;
        for (int p = 0; p < NUM_WB; p++) begin
            if (wb_cur[p].valid && wb_cur[p].is_load)
                busy_d[wb_cur[p].rd] = 1'b0;
        end
        if (bus.ld_issue_valid && (bus.ld_issue_rd != '0))
            busy_d[bus.ld_issue_rd] = 1'b1;
        if (bus.flush)
            busy_d = '0;
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (rst)
            busy_q <= '0;
        else
            busy_q <= busy_d;
    end

    // Saturating stall-cycle counter; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else if (stall_w && (cnt_q != 16'hFFFF))
            cnt_q <= cnt_q + 16'd1;
    end

    assign bus.stall_cnt = cnt_q;

endmodule

// File: tb/tb_bypass_scoreboard.sv
// Random and directed checks of bypass_scoreboard against a behavioural
// model, on a WB+1 build and a register-file write-through build.
module tb_bypass_scoreboard;
    import bypass_pkg::*;

    localparam int NW  = 3;
    localparam int NL  = 4;
    localparam int NSL = 2 * NL;
    localparam int NR  = 32;
    localparam int RWL = 5;

    logic clk = 1'b0;
    logic rst;
    bit   chk_en = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    bypass_scoreboard_if #(.NUM_WB(NW), .NUM_LANES(NL), .XLEN(32), .RW(RWL)) b0 ();
    bypass_scoreboard_if #(.NUM_WB(NW), .NUM_LANES(NL), .XLEN(32), .RW(RWL)) b1 ();

    assign b1.wb_valid       = b0.wb_valid;
    assign b1.wb_rd          = b0.wb_rd;
    assign b1.wb_data        = b0.wb_data;
    assign b1.wb_is_load     = b0.wb_is_load;
    assign b1.ex_valid       = b0.ex_valid;
    assign b1.ex_rs          = b0.ex_rs;
    assign b1.ld_issue_valid = b0.ld_issue_valid;
    assign b1.ld_issue_rd    = b0.ld_issue_rd;
    assign b1.flush          = b0.flush;

    bypass_scoreboard #(.RF_WRITE_THROUGH(1'b0)) u_wb1 (
        .clk (clk), .rst (rst), .bus (b0)
    );
    bypass_scoreboard #(.RF_WRITE_THROUGH(1'b1)) u_wt (
        .clk (clk), .rst (rst), .bus (b1)
    );

    // Behavioural state: what the pipeline "remembers" between cycles.
    bit          m_busy [NR];
    bit          m_pv [NW];
    logic [4:0]  m_prd [NW];
    logic [31:0] m_pd [NW];
    int          m_cnt;

    initial begin
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        foreach (m_pv[i]) m_pv[i] = 1'b0;
        m_cnt = 0;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad < 40)
                $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Newest value for a register: this cycle's ports, then last cycle's.
    function automatic void m_fwd(input int s, input bit wt,
                                  output bit en, output logic [31:0] d);
        logic [4:0] r;
        r  = b0.ex_rs[s];
        en = 1'b0;
        d  = 32'h0;
        if (r == 5'd0) return;
        for (int p = 0; p < NW; p++)
            if (b0.wb_valid[p] && b0.wb_rd[p] == r) begin
                en = 1'b1; d = b0.wb_data[p]; return;
            end
        if (wt) return;
        for (int p = 0; p < NW; p++)
            if (m_pv[p] && m_prd[p] == r) begin
                en = 1'b1; d = m_pd[p]; return;
            end
    endfunction

    function automatic bit m_stall();
        logic [4:0] r;
        bit arriving;
        for (int s = 0; s < NSL; s++) begin
            r = b0.ex_rs[s];
            arriving = 1'b0;
            for (int p = 0; p < NW; p++)
                if (b0.wb_valid[p] && b0.wb_is_load[p] && b0.wb_rd[p] == r)
                    arriving = 1'b1;
            if (b0.ex_valid[s/2] && r != 0 && m_busy[r] && !arriving)
                return 1'b1;
        end
        return 1'b0;
    endfunction

    // Compare both builds against the model, then advance the model.
    always @(negedge clk) begin
        bit          en;
        logic [31:0] d;
        bit          st;
        st = m_stall();
        if (chk_en) begin
            for (int s = 0; s < NSL; s++) begin
                m_fwd(s, 1'b0, en, d);
                chk($sformatf("wb1 fwd_en[%0d]", s), 32'(b0.fwd_en[s]), 32'(en));
                chk($sformatf("wb1 fwd_data[%0d]", s), b0.fwd_data[s], d);
                m_fwd(s, 1'b1, en, d);
                chk($sformatf("wt fwd_en[%0d]", s), 32'(b1.fwd_en[s]), 32'(en));
                chk($sformatf("wt fwd_data[%0d]", s), b1.fwd_data[s], d);
            end
            chk("wb1 stall", 32'(b0.stall), 32'(st));
            chk("wt stall", 32'(b1.stall), 32'(st));
            chk("wb1 stall_cnt", 32'(b0.stall_cnt), 32'(m_cnt));
            chk("wt stall_cnt", 32'(b1.stall_cnt), 32'(m_cnt));
        end
        if (rst) begin
            m_cnt = 0;
            foreach (m_busy[i]) m_busy[i] = 1'b0;
        end else begin
            if (st && m_cnt < 65535) m_cnt++;
            for (int p = 0; p < NW; p++)
                if (b0.wb_valid[p] && b0.wb_is_load[p])
                    m_busy[b0.wb_rd[p]] = 1'b0;
            if (b0.ld_issue_valid && b0.ld_issue_rd != 0)
                m_busy[b0.ld_issue_rd] = 1'b1;
            if (b0.flush)
                foreach (m_busy[i]) m_busy[i] = 1'b0;
        end
        for (int p = 0; p < NW; p++) begin
            m_pv[p]  = b0.wb_valid[p] && !b0.flush && !rst;
            m_prd[p] = b0.wb_rd[p];
            m_pd[p]  = b0.wb_data[p];
        end
    end

    task automatic idle();
        b0.wb_valid       = '0;
        b0.wb_rd          = '0;
        b0.wb_data        = '0;
        b0.wb_is_load     = '0;
        b0.ex_valid       = '0;
        b0.ex_rs          = '0;
        b0.ld_issue_valid = 1'b0;
        b0.ld_issue_rd    = '0;
        b0.flush          = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        cyc();
        cyc();
        rst = 1'b0;
        chk_en = 1'b1;
        #1;
        chk("reset fwd_en", 32'(b0.fwd_en), 32'h0);
        chk("reset stall", 32'(b0.stall), 32'h0);
        chk("reset stall_cnt", 32'(b0.stall_cnt), 32'h0);

        cyc();
        b0.wb_valid   = 3'b010;
        b0.wb_rd[1]   = 5'd5;
        b0.wb_data[1] = 32'hDEADBEEF;
        b0.ex_valid   = 4'b0001;
        b0.ex_rs[0]   = 5'd5;
        #1;
        chk("port1 fwd_en", 32'(b0.fwd_en), 32'h01);
        chk("port1 fwd_data", b0.fwd_data[0], 32'hDEADBEEF);

        cyc();
        idle();
        b0.wb_valid   = 3'b101;
        b0.wb_rd[0]   = 5'd7;
        b0.wb_data[0] = 32'h11;
        b0.wb_rd[2]   = 5'd7;
        b0.wb_data[2] = 32'h22;
        b0.ex_valid   = 4'b1000;
        b0.ex_rs[7]   = 5'd7;
        #1;
        chk("prio fwd_en", 32'(b0.fwd_en), 32'h80);
        chk("prio fwd_data", b0.fwd_data[7], 32'h11);
        cyc();
        b0.wb_valid = '0;
        #1;
        chk("wb1 fwd_en", 32'(b0.fwd_en[7]), 32'h1);
        chk("wb1 fwd_data", b0.fwd_data[7], 32'h11);
        chk("wt fwd_en", 32'(b1.fwd_en[7]), 32'h0);

        cyc();
        idle();
        b0.ld_issue_valid = 1'b1;
        b0.ld_issue_rd    = 5'd9;
        cyc();
        idle();
        b0.ex_valid = 4'b0010;
        b0.ex_rs[2] = 5'd9;
        #1;
        chk("load-use stall", 32'(b0.stall), 32'h1);
        chk("stall_cnt before", 32'(b0.stall_cnt), 32'h0);
        cyc();
        b0.wb_valid      = 3'b100;
        b0.wb_is_load    = 3'b100;
        b0.wb_rd[2]      = 5'd9;
        b0.wb_data[2]    = 32'h55;
        #1;
        chk("stall_cnt after", 32'(b0.stall_cnt), 32'h1);
        chk("return stall", 32'(b0.stall), 32'h0);
        chk("return fwd_en", 32'(b0.fwd_en[2]), 32'h1);
        chk("return fwd_data", b0.fwd_data[2], 32'h55);
        cyc();
        b0.wb_valid   = '0;
        b0.wb_is_load = '0;
        #1;
        chk("busy9 cleared", 32'(b0.stall), 32'h0);

        cyc();
        idle();
        b0.wb_valid   = 3'b001;
        b0.wb_data[0] = 32'hFF;
        b0.ex_valid   = 4'b0001;
        #1;
        chk("r0 fwd_en", 32'(b0.fwd_en), 32'h0);
        cyc();
        idle();
        b0.ld_issue_valid = 1'b1;
        cyc();
        idle();
        b0.ex_valid = 4'b1111;
        #1;
        chk("r0 stall", 32'(b0.stall), 32'h0);

        cyc();
        idle();
        b0.ld_issue_valid = 1'b1;
        b0.ld_issue_rd    = 5'd4;
        b0.flush          = 1'b1;
        cyc();
        idle();
        b0.ex_valid = 4'b0001;
        b0.ex_rs[0] = 5'd4;
        #1;
        chk("flush beats set", 32'(b0.stall), 32'h0);
        cyc();
        idle();
        b0.ld_issue_valid = 1'b1;
        b0.ld_issue_rd    = 5'd4;
        b0.wb_valid       = 3'b001;
        b0.wb_is_load     = 3'b001;
        b0.wb_rd[0]       = 5'd4;
        cyc();
        idle();
        b0.ex_valid = 4'b0001;
        b0.ex_rs[0] = 5'd4;
        #1;
        chk("set beats clear", 32'(b0.stall), 32'h1);
        cyc();
        idle();
        b0.flush = 1'b1;

        for (int n = 0; n < 3000; n++) begin
            cyc();
            rst                = ($urandom_range(0, 99) == 0);
            b0.flush           = ($urandom_range(0, 39) == 0);
            b0.wb_valid        = NW'($urandom);
            b0.wb_is_load      = NW'($urandom);
            b0.ex_valid        = NL'($urandom);
            b0.ld_issue_valid  = ($urandom_range(0, 2) == 0);
            b0.ld_issue_rd     = 5'($urandom_range(0, 7));
            for (int p = 0; p < NW; p++) begin
                b0.wb_rd[p]   = 5'($urandom_range(0, 7));
                b0.wb_data[p] = $urandom;
            end
            for (int s = 0; s < NSL; s++)
                b0.ex_rs[s] = 5'($urandom_range(0, 7));
        end

        cyc();
        rst = 1'b0;
        idle();
        b0.flush = 1'b1;
        cyc();
        idle();
        b0.ld_issue_valid = 1'b1;
        b0.ld_issue_rd    = 5'd3;
        cyc();
        idle();
        b0.ex_valid = 4'b0001;
        b0.ex_rs[0] = 5'd3;
        repeat (70000) cyc();
        chk("saturated stall_cnt", 32'(b0.stall_cnt), 32'hFFFF);
        rst = 1'b1;
        cyc();
        chk("rst stall", 32'(b0.stall), 32'h0);
        chk("rst stall_cnt", 32'(b0.stall_cnt), 32'h0);
        chk("rst fwd_en", 32'(b0.fwd_en), 32'h0);
        rst = 1'b0;
        cyc();
        chk("rst busy cleared", 32'(b0.stall), 32'h0);
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
